prga: RTL and testbench
=======================

PRGA -- requirements
Module: prga

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 8 bits.
REQ-002 clk  in  1  single clock; all state SHALL change on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 en  in  1  start request; sampled only while rdy=1.
REQ-005 rdy  out  1  high = idle and able to accept en.
REQ-006 s_addr  out  8  S-box RAM address.
REQ-007 s_rddata  in  8  S-box RAM read data; synchronous read, valid the cycle after s_addr.
REQ-008 s_wrdata  out  8  S-box RAM write data.
REQ-009 s_wren  out  1  S-box RAM write enable.
REQ-010 ct_addr  out  8  ciphertext RAM address; byte 0 holds the message length, bytes 1..len hold data.
REQ-011 ct_rddata  in  8  ciphertext read data, 1-cycle latency.
REQ-012 pt_addr  out  8  plaintext RAM address.
REQ-013 pt_wrdata  out  8  plaintext write data.
REQ-014 pt_wren  out  1  plaintext write enable.

Function
REQ-015 The block SHALL run the RC4 PRGA over the S-box left by the key schedule, with i=j=0 at start, and SHALL write pt[0]=len and pt[k]=ct[k] XOR pad[k] for k=1..len.
REQ-016 Handshake: the block SHALL accept en=1 at a rising edge only when rdy=1; rdy SHALL drop in the following cycle; en SHALL be ignored while rdy=0.
REQ-017 States and per-state actions:
- IDLE: rdy=1. On en: clear i and j, set k=1, go to RD_LEN.
- RD_LEN: ct_addr=0.
- LD_LEN: len<=ct_rddata; pt_addr=0, pt_wrdata=ct_rddata, pt_wren=1. Go to IDLE if len==0, otherwise to RD_SI.
- RD_SI: i<=i+1; s_addr=i+1.
- WT_SI: si<=s_rddata; j<=j+s_rddata; s_addr=j+s_rddata.
- WT_SJ: sj<=s_rddata.
- WR_SI: s_addr=i, s_wrdata=sj, s_wren=1.
- WR_SJ: s_addr=j, s_wrdata=si, s_wren=1.
- RD_PAD: s_addr=si+sj, ct_addr=k.
- WT_PAD: pt_addr=k, pt_wrdata=s_rddata^ct_rddata, pt_wren=1. Go to IDLE if k==len; otherwise k<=k+1 and go to RD_SI.
REQ-018 All index arithmetic (i, j, si+sj, k) SHALL be 8-bit modulo 256; i SHALL wrap 255->0 without error.
REQ-019 Latency: each plaintext byte SHALL take exactly 7 cycles; rdy SHALL return high exactly 2+7*len cycles after the accepting edge.
REQ-020 When i==j, the swap SHALL still perform both writes, which leaves S unchanged.
REQ-021 len==0 SHALL write only pt[0]=0, SHALL perform no S reads or writes, and SHALL return rdy=1 after 2 cycles.
REQ-022 s_wren and pt_wren SHALL be 0 in every state not listed above as writing, including IDLE.
REQ-023 The block SHALL NOT read or write any RAM while in IDLE, so the key-schedule blocks can own the S-box RAM at that time.

Reset
REQ-024 While rst_n=0, outputs SHALL be: state=IDLE, rdy=1, s_wren=0, pt_wren=0, all addresses and data outputs=0, and i, j, k, len, si, sj=0.
REQ-025 Reset asserted mid-message SHALL abort at once to IDLE. The block SHALL NOT restore RAM contents; partially swapped S and partially written pt are left as they are.

Verification
REQ-026 Reset: rst_n=0 at any state -> rdy=1 and s_wren=pt_wren=0 with no clock edge required.
REQ-027 Zero length: ct[0]=0x00, pulse en -> pt[0]=0x00, no s_wren pulse, rdy high 2 cycles after accept.
REQ-028 Single byte, identity S (S[x]=x): ct={0x01,0x00} -> pt={0x01,0x02}, S unchanged (i=j=1 case), rdy after 9 cycles.
REQ-029 Two bytes, identity S: ct={0x02,0xFF,0x00} -> pt={0x02,0xFD,0x05}, final S[2]=0x03 and S[3]=0x02, rest identity, rdy after 16 cycles.
REQ-030 Handshake: hold en=1 for the whole run, and also pulse en mid-run -> exactly one message processed; with en still high at completion, a new run starts on the first cycle of rdy=1.
REQ-031 Wrap and abort: len=0xFF -> i wraps through 255, 255 pt writes plus pt[0], rdy after 1787 cycles; a rerun with rst_n pulsed at cycle 100 -> immediate IDLE, no further writes.

Source files
------------

// File: rtl/prga.sv
// prga: RC4 pseudo-random generation over a shared S-box RAM, decrypting ct into pt.
// Addresses and write strobes are decoded from the registered state so that the same-cycle RAM data can be used.
module prga (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);
    typedef enum logic [3:0] {
        IDLE, RD_LEN, LD_LEN, RD_SI, WT_SI, WT_SJ, WR_SI, WR_SJ, RD_PAD, WT_PAD
    } state_t;
    state_t     state;
    logic [7:0] i, j, k, len, si, sj;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            len   <= '0;
            si    <= '0;
            sj    <= '0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    i     <= '0;
                    j     <= '0;
                    k     <= 8'd1;
                    state <= RD_LEN;
                end
                RD_LEN: state <= LD_LEN;
                LD_LEN: begin
                    len   <= ct_rddata;
                    state <= (ct_rddata == 8'd0) ? IDLE : RD_SI;
                end
                RD_SI: begin
                    i     <= i + 8'd1;
                    state <= WT_SI;
                end
                WT_SI: begin
                    si    <= s_rddata;
                    j     <= j + s_rddata;
                    state <= WT_SJ;
                end
                WT_SJ: begin
                    sj    <= s_rddata;
                    state <= WR_SI;
                end
                WR_SI:  state <= WR_SJ;
                WR_SJ:  state <= RD_PAD;
                RD_PAD: state <= WT_PAD;
                WT_PAD: begin
                    k     <= (k == len) ? k : k + 8'd1;
                    state <= (k == len) ? IDLE : RD_SI;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // IDLE drives every address and strobe to zero, leaving the S-box RAM free for the key schedule.
    always_comb begin
        rdy       = (state == IDLE);
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;
        case (state)
            LD_LEN: begin
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
            end
            RD_SI: s_addr = i + 8'd1;
            WT_SI: s_addr = j + s_rddata;
            WR_SI: begin
                s_addr   = i;
                s_wrdata = sj;
                s_wren   = 1'b1;
            end
            WR_SJ: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
            end
            RD_PAD: begin
                s_addr  = si + sj;
                ct_addr = k;
            end
            WT_PAD: begin
                pt_addr   = k;
                pt_wrdata = s_rddata ^ ct_rddata;
                pt_wren   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_prga.sv
// tb_prga: RAM models, RC4 reference model and per-cycle rdy/idle checks for prga.
module tb_prga;
    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic       rdy, s_wren, pt_wren;
    logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
    logic [7:0] smem [256];
    logic [7:0] ctmem [256];
    logic [7:0] ptmem [256];
    logic [7:0] exp_s [256];
    logic [7:0] exp_pt [256];
    int s_wr_cnt = 0, pt_wr_cnt = 0, checks = 0, fails = 0;
    bit mrdy = 1'b1;
    int rem = 0;
    int cyc, s0, p0;

    always #5 clk = ~clk;

    prga dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .ct_addr(ct_addr), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    // synchronous-read RAMs, read-before-write
    always @(posedge clk) begin
        s_rddata  <= smem[s_addr];
        ct_rddata <= ctmem[ct_addr];
        if (s_wren) begin
            smem[s_addr] = s_wrdata;
            s_wr_cnt = s_wr_cnt + 1;
        end
        if (pt_wren) begin
            ptmem[pt_addr] = pt_wrdata;
            pt_wr_cnt = pt_wr_cnt + 1;
        end
    end

    // timing model: a message of length n keeps the block busy 2+7n cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mrdy = 1'b1;
            rem  = 0;
        end else if (mrdy) begin
            if (en) begin
                mrdy = 1'b0;
                rem  = 2 + 7 * int'(ctmem[0]);
            end
        end else begin
            rem = rem - 1;
            if (rem == 0) mrdy = 1'b1;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (rdy !== mrdy) begin
            fails++;
            $display("FAIL rdy_cycle: got %b expected %b at %0t", rdy, mrdy, $time);
        end
        if (mrdy) begin
            checks++;
            if (s_wren !== 1'b0 || pt_wren !== 1'b0) begin
                fails++;
                $display("FAIL idle_wren: got s_wren=%b pt_wren=%b expected 0/0 at %0t", s_wren, pt_wren, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
        end
    endtask

    task automatic model(input int n);
        logic [7:0] s [256];
        logic [7:0] mi, mj, t;
        for (int x = 0; x < 256; x++) begin
            s[x] = smem[x];
            exp_pt[x] = ptmem[x];
        end
        exp_pt[0] = 8'(n);
        mi = 0;
        mj = 0;
        for (int m = 1; m <= n; m++) begin
            mi = mi + 8'd1;
            mj = mj + s[mi];
            t = s[mi];
            s[mi] = s[mj];
            s[mj] = t;
            t = s[mi] + s[mj];
            exp_pt[m] = ctmem[m] ^ s[t];
        end
        for (int x = 0; x < 256; x++) exp_s[x] = s[x];
    endtask

    function automatic int diff_s();
        int d = 0;
        for (int x = 0; x < 256; x++) if (smem[x] !== exp_s[x]) d++;
        return d;
    endfunction

    function automatic int diff_pt();
        int d = 0;
        for (int x = 0; x < 256; x++) if (ptmem[x] !== exp_pt[x]) d++;
        return d;
    endfunction

    function automatic int non_identity();
        int d = 0;
        for (int x = 0; x < 256; x++) if (smem[x] !== 8'(x)) d++;
        return d;
    endfunction

    task automatic setup(input int mult, input int add);
        for (int x = 0; x < 256; x++) begin
            smem[x]  = 8'(x * mult + add);
            ptmem[x] = 8'hAA;
        end
    endtask

    task automatic start(input int n, input bit hold);
        ctmem[0] = 8'(n);
        model(n);
        s0 = s_wr_cnt;
        p0 = pt_wr_cnt;
        @(posedge clk); #2;
        chk("rdy_before_start", rdy, 1);
        en = 1'b1;
        @(posedge clk); #2;
        en = hold;
        cyc = 0;
    endtask

    task automatic run(input int n, input bit hold);
        start(n, hold);
        while (!rdy && cyc < 2000) begin
            @(posedge clk); #2;
            cyc++;
            if (hold && cyc == 5) en = 1'b0;
            if (hold && cyc == 6) en = 1'b1;
        end
        if (!hold) en = 1'b0;
        chk("done_in_budget", rdy, 1);
        chk("pt_model_diffs", diff_pt(), 0);
        chk("s_model_diffs", diff_s(), 0);
        chk("s_write_count", s_wr_cnt - s0, 2 * n);
        chk("pt_write_count", pt_wr_cnt - p0, n + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1);
    end

    initial begin
        setup(1, 0);
        for (int x = 0; x < 256; x++) ctmem[x] = 8'h00;
        #1;
        chk("reset_rdy", rdy, 1);
        chk("reset_wrens", {s_wren, pt_wren}, 0);
        chk("reset_addrs", {s_addr, ct_addr, pt_addr}, 0);
        chk("reset_data", {s_wrdata, pt_wrdata}, 0);
        #20;
        @(posedge clk); #2;
        rst_n = 1'b1;

        // zero length
        run(0, 1'b0);
        chk("len0_latency", cyc, 2);
        chk("len0_pt0", ptmem[0], 8'h00);

        // single byte, identity S, i==j swap
        setup(1, 0);
        ctmem[1] = 8'h00;
        run(1, 1'b0);
        chk("len1_latency", cyc, 9);
        chk("len1_pt0", ptmem[0], 8'h01);
        chk("len1_pt1", ptmem[1], 8'h02);
        chk("len1_s_identity", non_identity(), 0);

        // two bytes, identity S
        setup(1, 0);
        ctmem[1] = 8'hFF;
        ctmem[2] = 8'h00;
        run(2, 1'b0);
        chk("len2_latency", cyc, 16);
        chk("len2_pt1", ptmem[1], 8'hFD);
        chk("len2_pt2", ptmem[2], 8'h05);
        chk("len2_s2", smem[2], 8'h03);
        chk("len2_s3", smem[3], 8'h02);
        chk("len2_s_changed", non_identity(), 2);

        // en held high with a mid-run pulse, then immediate restart
        setup(1, 0);
        ctmem[1] = 8'h5A;
        run(1, 1'b1);
        chk("hold_latency", cyc, 9);
        chk("hold_pt1", ptmem[1], 8'h58);
        @(posedge clk); #2;
        chk("hold_restart", rdy, 0);
        en = 1'b0;
        cyc = 0;
        while (!rdy && cyc < 100) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk("hold_second_run", cyc, 9);

        // full length with a non-identity permutation
        setup(7, 3);
        for (int x = 1; x < 256; x++) ctmem[x] = 8'($urandom);
        run(255, 1'b0);
        chk("len255_latency", cyc, 1787);

        // abort mid-message with reset
        setup(1, 0);
        start(255, 1'b0);
        while (cyc < 100) begin
            @(posedge clk); #2;
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_rdy", rdy, 1);
        chk("abort_wrens", {s_wren, pt_wren}, 0);
        chk("abort_pt_writes", pt_wr_cnt - p0, 15);
        chk("abort_s_writes", s_wr_cnt - s0, 28);
        chk("abort_pt14", ptmem[14], exp_pt[14]);
        chk("abort_pt15", ptmem[15], 8'hAA);
        s0 = s_wr_cnt;
        p0 = pt_wr_cnt;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        chk("post_abort_idle", rdy, 1);
        chk("post_abort_writes", (s_wr_cnt - s0) + (pt_wr_cnt - p0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
